// File: rtl/axi_wr_buffer.sv
// -----------------------------------------------------------------------------
// axi_wr_buffer
//
// Buffers write commands and write data from a local producer and issues them
// as AXI write bursts. A burst is started only after all of its beats are in
// the data FIFO, so the W channel never stalls for lack of data once AW has
// been accepted. The number of bursts waiting for a B response is capped.
//
// Parameters
//   AXI_ADDR_WIDTH   write address width
//   AXI_DATA_WIDTH   data width, multiple of 8, 32..1024
//   CMD_DEPTH        command FIFO depth, power of two, >= 2
//   DATA_DEPTH       data FIFO depth in beats, power of two, >= 256
//   MAX_OUTSTANDING  bursts allowed without a B response, 1..15
//
// Ports
//   axi_clk, reset                   single clock, synchronous active-high reset
//   wr_req_en/wr_addr_in/wr_burst_len  command push (len is beats-1)
//   wr_cmd_ready                     command FIFO not full
//   wr_data_valid/_in/_strb/_last    data push
//   wr_data_ready                    data FIFO not full
//   axi_aw_*, axi_w_*, axi_b_*       AXI write address / data / response
//   outstanding                      bursts accepted on AW awaiting B
//   err_wcmd_fifo, err_wdata_fifo    push into a full FIFO (entry dropped)
//   err_last                         stored last flag disagrees with the count
//   err_bresp                        non-OKAY B response
// All err_* outputs are single-cycle pulses, one cycle after the event.
// -----------------------------------------------------------------------------
module axi_wr_buffer #(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 128,
  parameter int CMD_DEPTH       = 16,
  parameter int DATA_DEPTH      = 512,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                        axi_clk,
  input  logic                        reset,

  input  logic                        wr_req_en,
  input  logic [AXI_ADDR_WIDTH-1:0]   wr_addr_in,
  input  logic [7:0]                  wr_burst_len,
  output logic                        wr_cmd_ready,

  input  logic                        wr_data_valid,
  input  logic [AXI_DATA_WIDTH-1:0]   wr_data_in,
  input  logic [AXI_DATA_WIDTH/8-1:0] wr_data_strb,
  input  logic                        wr_data_last,
  output logic                        wr_data_ready,

  output logic                        axi_aw_valid,
  input  logic                        axi_aw_ready,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr,
  output logic [7:0]                  axi_aw_len,

  output logic                        axi_w_valid,
  input  logic                        axi_w_ready,
  output logic [AXI_DATA_WIDTH-1:0]   axi_w_data,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb,
  output logic                        axi_w_last,

  input  logic                        axi_b_valid,
  output logic                        axi_b_ready,
  input  logic [1:0]                  axi_b_resp,

  output logic [3:0]                  outstanding,

  output logic                        err_wcmd_fifo,
  output logic                        err_wdata_fifo,
  output logic                        err_last,
  output logic                        err_bresp
);

  localparam int STRB_WIDTH   = AXI_DATA_WIDTH / 8;
  localparam int CMD_PTR_W    = $clog2(CMD_DEPTH);
  localparam int CMD_CNT_W    = CMD_PTR_W + 1;
  localparam int DATA_PTR_W   = $clog2(DATA_DEPTH);
  localparam int DATA_CNT_W   = DATA_PTR_W + 1;
  localparam int DATA_ENTRY_W = 1 + STRB_WIDTH + AXI_DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2
  } state_t;

  state_t state, state_next;

  // ---------------------------------------------------------------------------
  // Command FIFO (first-word-fall-through: head is read combinationally)
  // ---------------------------------------------------------------------------
  logic [AXI_ADDR_WIDTH-1:0] cmd_addr_mem [CMD_DEPTH];
  logic [7:0]                cmd_len_mem  [CMD_DEPTH];
  logic [CMD_PTR_W-1:0]      cmd_wr_ptr;
  logic [CMD_PTR_W-1:0]      cmd_rd_ptr;
  logic [CMD_CNT_W-1:0]      cmd_count;
  logic                      cmd_full;
  logic                      cmd_empty;
  logic                      cmd_push;
  logic                      cmd_pop;
  logic [AXI_ADDR_WIDTH-1:0] cmd_addr_head;
  logic [7:0]                cmd_len_head;

  assign cmd_full      = (cmd_count == CMD_CNT_W'(CMD_DEPTH));
  assign cmd_empty     = (cmd_count == '0);
  assign cmd_push      = wr_req_en && !cmd_full;
  assign cmd_addr_head = cmd_addr_mem[cmd_rd_ptr];
  assign cmd_len_head  = cmd_len_mem[cmd_rd_ptr];
  assign wr_cmd_ready  = !cmd_full;

  // NOTE: storage arrays carry no reset; an entry is only read after the
  // pointers say it was written, so clearing them would only cost flops.
  always_ff @(posedge axi_clk) begin
    if (cmd_push) begin
      cmd_addr_mem[cmd_wr_ptr] <= wr_addr_in;
      cmd_len_mem[cmd_wr_ptr]  <= wr_burst_len;
    end
  end

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge axi_clk) begin
    if (reset) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_count  <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
      if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_count <= cmd_count + 1'b1;
        2'b01:   cmd_count <= cmd_count - 1'b1;
        default: cmd_count <= cmd_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Data FIFO, entry = {last, strb, data}
  // ---------------------------------------------------------------------------
  logic [DATA_ENTRY_W-1:0]   data_mem [DATA_DEPTH];
  logic [DATA_PTR_W-1:0]     data_wr_ptr;
  logic [DATA_PTR_W-1:0]     data_rd_ptr;
  logic [DATA_CNT_W-1:0]     data_count;
  logic                      data_full;
  logic                      data_push;
  logic                      data_pop;
  logic [DATA_ENTRY_W-1:0]   data_head;
  logic [AXI_DATA_WIDTH-1:0] data_head_data;
  logic [STRB_WIDTH-1:0]     data_head_strb;
  logic                      data_head_last;

  assign data_full      = (data_count == DATA_CNT_W'(DATA_DEPTH));
  assign data_push      = wr_data_valid && !data_full;
  assign data_head      = data_mem[data_rd_ptr];
  assign data_head_data = data_head[AXI_DATA_WIDTH-1:0];
  assign data_head_strb = data_head[AXI_DATA_WIDTH +: STRB_WIDTH];
  assign data_head_last = data_head[DATA_ENTRY_W-1];
  assign wr_data_ready  = !data_full;

  always_ff @(posedge axi_clk) begin
    if (data_push) begin
      data_mem[data_wr_ptr] <= {wr_data_last, wr_data_strb, wr_data_in};
    end
  end

  always_ff @(posedge axi_clk) begin
    if (reset) begin
      data_wr_ptr <= '0;
      data_rd_ptr <= '0;
      data_count  <= '0;
    end else begin
      if (data_push) data_wr_ptr <= data_wr_ptr + 1'b1;
      if (data_pop)  data_rd_ptr <= data_rd_ptr + 1'b1;
      case ({data_push, data_pop})
        2'b10:   data_count <= data_count + 1'b1;
        2'b01:   data_count <= data_count - 1'b1;
        default: data_count <= data_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Burst control
  // ---------------------------------------------------------------------------
  logic [7:0]            beat_cnt;
  logic                  gen_last;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  b_hs;
  logic [DATA_CNT_W-1:0] beats_needed;
  logic                  burst_ready;

  assign aw_hs    = (state == ST_AW) && axi_aw_ready;
  assign w_hs     = (state == ST_W)  && axi_w_ready;
  assign b_hs     = axi_b_valid && axi_b_ready;
  assign cmd_pop  = aw_hs;
  assign data_pop = w_hs;

  // The burst length comes from the command, never from the stored last flag,
  // so a malformed producer stream cannot shorten or stretch a burst.
  assign gen_last = (beat_cnt == 8'd0);

  // Only launch once every beat of the head command is already buffered.
  assign beats_needed = DATA_CNT_W'(cmd_len_head) + DATA_CNT_W'(1);
  assign burst_ready  = !cmd_empty
                     && (data_count >= beats_needed)
                     && (outstanding < 4'(MAX_OUTSTANDING));

  assign axi_b_ready = (outstanding != 4'd0);

  always_ff @(posedge axi_clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    axi_aw_valid = 1'b0;
    axi_aw_addr  = '0;
    axi_aw_len   = '0;
    axi_w_valid  = 1'b0;
    axi_w_data   = '0;
    axi_w_strb   = '0;
    axi_w_last   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (burst_ready) state_next = ST_AW;
      end
      ST_AW: begin
        axi_aw_valid = 1'b1;
        axi_aw_addr  = cmd_addr_head;
        axi_aw_len   = cmd_len_head;
        if (axi_aw_ready) state_next = ST_W;
      end
      ST_W: begin
        axi_w_valid = 1'b1;
        axi_w_data  = data_head_data;
        axi_w_strb  = data_head_strb;
        axi_w_last  = gen_last;
        if (axi_w_ready && gen_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (reset) begin
      beat_cnt <= '0;
    end else if (aw_hs) begin
      beat_cnt <= cmd_len_head;
    end else if (w_hs && !gen_last) begin
      beat_cnt <= beat_cnt - 8'd1;
    end
  end

  // A simultaneous AW and B handshake cancel out.
  always_ff @(posedge axi_clk) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({aw_hs, b_hs})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Error pulses, registered so each is high for exactly one cycle
  // ---------------------------------------------------------------------------
  always_ff @(posedge axi_clk) begin
    if (reset) begin
      err_wcmd_fifo  <= 1'b0;
      err_wdata_fifo <= 1'b0;
      err_last       <= 1'b0;
      err_bresp      <= 1'b0;
    end else begin
      err_wcmd_fifo  <= wr_req_en && cmd_full;
      err_wdata_fifo <= wr_data_valid && data_full;
      err_last       <= w_hs && (data_head_last != gen_last);
      err_bresp      <= b_hs && (axi_b_resp != 2'b00);
    end
  end

endmodule

// File: tb/tb_axi_wr_buffer.sv
// -----------------------------------------------------------------------------
// tb_axi_wr_buffer
//
// Directed bench for axi_wr_buffer. AW and W handshakes are compared against
// scoreboard queues filled when the commands and beats are pushed. The DUT is
// built with MAX_OUTSTANDING=2 and a 4-entry command FIFO so the limit and
// the full-FIFO cases are reached quickly.
// -----------------------------------------------------------------------------
module tb_axi_wr_buffer;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int CD = 4;
  localparam int DD = 256;
  localparam int MO = 2;

  logic          axi_clk;
  logic          reset;
  logic          wr_req_en;
  logic [AW-1:0] wr_addr_in;
  logic [7:0]    wr_burst_len;
  logic          wr_cmd_ready;
  logic          wr_data_valid;
  logic [DW-1:0] wr_data_in;
  logic [SW-1:0] wr_data_strb;
  logic          wr_data_last;
  logic          wr_data_ready;
  logic          axi_aw_valid;
  logic          axi_aw_ready;
  logic [AW-1:0] axi_aw_addr;
  logic [7:0]    axi_aw_len;
  logic          axi_w_valid;
  logic          axi_w_ready;
  logic [DW-1:0] axi_w_data;
  logic [SW-1:0] axi_w_strb;
  logic          axi_w_last;
  logic          axi_b_valid;
  logic          axi_b_ready;
  logic [1:0]    axi_b_resp;
  logic [3:0]    outstanding;
  logic          err_wcmd_fifo;
  logic          err_wdata_fifo;
  logic          err_last;
  logic          err_bresp;

  axi_wr_buffer #(
    .AXI_ADDR_WIDTH (AW),
    .AXI_DATA_WIDTH (DW),
    .CMD_DEPTH      (CD),
    .DATA_DEPTH     (DD),
    .MAX_OUTSTANDING(MO)
  ) dut (
    .axi_clk       (axi_clk),
    .reset         (reset),
    .wr_req_en     (wr_req_en),
    .wr_addr_in    (wr_addr_in),
    .wr_burst_len  (wr_burst_len),
    .wr_cmd_ready  (wr_cmd_ready),
    .wr_data_valid (wr_data_valid),
    .wr_data_in    (wr_data_in),
    .wr_data_strb  (wr_data_strb),
    .wr_data_last  (wr_data_last),
    .wr_data_ready (wr_data_ready),
    .axi_aw_valid  (axi_aw_valid),
    .axi_aw_ready  (axi_aw_ready),
    .axi_aw_addr   (axi_aw_addr),
    .axi_aw_len    (axi_aw_len),
    .axi_w_valid   (axi_w_valid),
    .axi_w_ready   (axi_w_ready),
    .axi_w_data    (axi_w_data),
    .axi_w_strb    (axi_w_strb),
    .axi_w_last    (axi_w_last),
    .axi_b_valid   (axi_b_valid),
    .axi_b_ready   (axi_b_ready),
    .axi_b_resp    (axi_b_resp),
    .outstanding   (outstanding),
    .err_wcmd_fifo (err_wcmd_fifo),
    .err_wdata_fifo(err_wdata_fifo),
    .err_last      (err_last),
    .err_bresp     (err_bresp)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } aw_exp_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
  } w_exp_t;

  aw_exp_t exp_aw[$];
  w_exp_t  exp_w[$];

  int n_vec  = 0;
  int n_fail = 0;
  int aw_count = 0;
  int w_count  = 0;
  int err_last_cnt  = 0;
  int err_bresp_cnt = 0;
  int err_wcmd_cnt  = 0;
  int err_wdata_cnt = 0;
  int aw_tgt = 0;
  int w_tgt  = 0;
  bit rand_wready = 1'b0;
  bit w_pend = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive phase: 1 ns after the rising edge.
  task automatic tick();
    @(posedge axi_clk);
    #1;
    if (rand_wready) axi_w_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_cmd(input logic [AW-1:0] addr, input logic [7:0] len, input bit accept);
    if (accept) exp_aw.push_back('{addr: addr, len: len});
    wr_req_en    = 1'b1;
    wr_addr_in   = addr;
    wr_burst_len = len;
    tick();
    wr_req_en = 1'b0;
  endtask

  task automatic push_beat(input logic [DW-1:0] data, input logic [SW-1:0] strb,
                           input logic stored_last, input logic exp_last);
    exp_w.push_back('{data: data, strb: strb, last: exp_last});
    wr_data_valid = 1'b1;
    wr_data_in    = data;
    wr_data_strb  = strb;
    wr_data_last  = stored_last;
    tick();
    wr_data_valid = 1'b0;
  endtask

  task automatic push_burst(input logic [AW-1:0] addr, input logic [7:0] len, input int tagv);
    push_cmd(addr, len, 1'b1);
    for (int i = 0; i <= int'(len); i++) begin
      push_beat({tagv[15:0], 16'(i), $urandom}, SW'($urandom), 1'(i == int'(len)),
                1'(i == int'(len)));
    end
  endtask

  task automatic wait_aw(input int target, input string tag);
    int budget = 0;
    while (aw_count < target && budget < 300) begin
      tick();
      budget++;
    end
    check(tag, 128'(aw_count >= target), 128'd1);
  endtask

  task automatic wait_w(input int target, input string tag);
    int budget = 0;
    while (w_count < target && budget < 300) begin
      tick();
      budget++;
    end
    check(tag, 128'(w_count >= target), 128'd1);
  endtask

  task automatic send_b(input logic [1:0] resp);
    check("b_ready_before_b", 128'(axi_b_ready), 128'd1);
    axi_b_valid = 1'b1;
    axi_b_resp  = resp;
    tick();
    axi_b_valid = 1'b0;
    axi_b_resp  = 2'b00;
  endtask

  // Monitor: samples on the falling edge; a valid&&ready seen here completes
  // at the following rising edge.
  always @(negedge axi_clk) begin
    if (reset) begin
      w_pend = 1'b0;
    end else begin
      if (w_pend) check("w_valid_held_mid_burst", 128'(axi_w_valid), 128'd1);
      if (axi_aw_valid && axi_aw_ready) begin
        check("aw_expected", 128'(exp_aw.size() != 0), 128'd1);
        if (exp_aw.size() != 0) begin
          aw_exp_t e;
          e = exp_aw.pop_front();
          check("aw_addr", 128'(axi_aw_addr), 128'(e.addr));
          check("aw_len", 128'(axi_aw_len), 128'(e.len));
        end
        aw_count++;
      end
      if (axi_w_valid && axi_w_ready) begin
        check("w_expected", 128'(exp_w.size() != 0), 128'd1);
        if (exp_w.size() != 0) begin
          w_exp_t e;
          e = exp_w.pop_front();
          check("w_data", 128'(axi_w_data), 128'(e.data));
          check("w_strb", 128'(axi_w_strb), 128'(e.strb));
          check("w_last", 128'(axi_w_last), 128'(e.last));
        end
        w_count++;
      end
      w_pend = axi_w_valid && !(axi_w_ready && axi_w_last);
      if (err_last)       err_last_cnt++;
      if (err_bresp)      err_bresp_cnt++;
      if (err_wcmd_fifo)  err_wcmd_cnt++;
      if (err_wdata_fifo) err_wdata_cnt++;
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    reset         = 1'b1;
    wr_req_en     = 1'b0;
    wr_addr_in    = '0;
    wr_burst_len  = '0;
    wr_data_valid = 1'b0;
    wr_data_in    = '0;
    wr_data_strb  = '0;
    wr_data_last  = 1'b0;
    axi_aw_ready  = 1'b1;
    axi_w_ready   = 1'b1;
    axi_b_valid   = 1'b0;
    axi_b_resp    = 2'b00;

    // ---- reset values ----
    repeat (3) tick();
    check("rst_aw_valid", 128'(axi_aw_valid), 128'd0);
    check("rst_w_valid_last", 128'({axi_w_valid, axi_w_last}), 128'd0);
    check("rst_outstanding", 128'(outstanding), 128'd0);
    check("rst_b_ready", 128'(axi_b_ready), 128'd0);
    check("rst_errs", 128'({err_wcmd_fifo, err_wdata_fifo, err_last, err_bresp}), 128'd0);
    check("rst_aw_addr_len", 128'({axi_aw_addr, axi_aw_len}), 128'd0);
    check("rst_w_data_strb", 128'({axi_w_data, axi_w_strb}), 128'd0);
    reset = 1'b0;
    tick();
    check("rdy_after_rst", 128'({wr_cmd_ready, wr_data_ready}), 128'd3);

    // ---- single burst: addr 0x1000, 4 beats ----
    push_burst(32'h1000, 8'd3, 1);
    aw_tgt++;
    wait_aw(aw_tgt, "t1_aw_issued");
    check("t1_outstanding_1", 128'(outstanding), 128'd1);
    w_tgt += 4;
    wait_w(w_tgt, "t1_w_beats");
    check("t1_outstanding_still_1", 128'(outstanding), 128'd1);
    send_b(2'b00);
    check("t1_outstanding_0", 128'(outstanding), 128'd0);

    // ---- data gating: len 7, only 5 beats at first ----
    push_cmd(32'h2000, 8'd7, 1'b1);
    for (int i = 0; i < 5; i++) push_beat({32'h2000_0000 + 32'(i), $urandom}, 8'hFF, 1'b0, 1'b0);
    repeat (6) begin
      tick();
      check("t2_aw_gated", 128'(axi_aw_valid), 128'd0);
    end
    for (int i = 5; i < 8; i++) push_beat({32'h2000_0000 + 32'(i), $urandom}, 8'hFF,
                                          1'(i == 7), 1'(i == 7));
    check("t2_aw_low_1_after_beat8", 128'(axi_aw_valid), 128'd0);
    tick();
    check("t2_aw_rise_2_after_beat8", 128'(axi_aw_valid), 128'd1);
    aw_tgt++;
    wait_aw(aw_tgt, "t2_aw_issued");
    w_tgt += 8;
    wait_w(w_tgt, "t2_w_beats");
    send_b(2'b00);

    // ---- outstanding limit: 3 bursts queued, no B ----
    push_burst(32'h3000, 8'd1, 3);
    push_burst(32'h3100, 8'd1, 4);
    push_burst(32'h3200, 8'd1, 5);
    aw_tgt += 2;
    wait_aw(aw_tgt, "t3_two_aw");
    w_tgt += 4;
    wait_w(w_tgt, "t3_two_bursts_data");
    repeat (20) tick();
    check("t3_aw_capped", 128'(aw_count), 128'(aw_tgt));
    check("t3_outstanding_max", 128'(outstanding), 128'd2);
    send_b(2'b00);
    aw_tgt++;
    wait_aw(aw_tgt, "t3_third_aw");
    w_tgt += 2;
    wait_w(w_tgt, "t3_third_data");
    send_b(2'b00);
    send_b(2'b00);
    check("t3_outstanding_0", 128'(outstanding), 128'd0);

    // ---- backpressure: random w_ready ----
    rand_wready = 1'b1;
    push_burst(32'h4000, 8'd15, 6);
    aw_tgt++;
    wait_aw(aw_tgt, "t4_aw");
    w_tgt += 16;
    wait_w(w_tgt, "t4_w_beats");
    send_b(2'b00);
    rand_wready = 1'b0;
    axi_w_ready = 1'b1;

    // ---- stored last on beat 2 of a len-3 burst ----
    e0 = err_last_cnt;
    push_cmd(32'h5000, 8'd3, 1'b1);
    push_beat(64'h5000_0000_0000_0000, 8'h0F, 1'b0, 1'b0);
    push_beat(64'h5000_0001_0000_0001, 8'hF0, 1'b1, 1'b0);
    push_beat(64'h5000_0002_0000_0002, 8'h3C, 1'b0, 1'b0);
    push_beat(64'h5000_0003_0000_0003, 8'hC3, 1'b1, 1'b1);
    aw_tgt++;
    wait_aw(aw_tgt, "t5_aw");
    w_tgt += 4;
    wait_w(w_tgt, "t5_four_beats");
    tick();
    check("t5_err_last_once", 128'(err_last_cnt - e0), 128'd1);
    e0 = err_bresp_cnt;
    send_b(2'b10);
    check("t5_err_bresp_pulse", 128'(err_bresp), 128'd1);
    tick();
    check("t5_err_bresp_clears", 128'(err_bresp), 128'd0);
    check("t5_err_bresp_once", 128'(err_bresp_cnt - e0), 128'd1);

    // ---- command FIFO overflow ----
    axi_aw_ready = 1'b0;
    for (int i = 0; i < CD; i++) push_cmd(32'h6000 + 32'(i * 16), 8'd0, 1'b1);
    check("t6_cmd_not_ready", 128'(wr_cmd_ready), 128'd0);
    check("t6_count_full", 128'(dut.cmd_count), 128'(CD));
    e0 = err_wcmd_cnt;
    push_cmd(32'h6F00, 8'd0, 1'b0);
    check("t6_err_wcmd_pulse", 128'(err_wcmd_fifo), 128'd1);
    check("t6_count_unchanged", 128'(dut.cmd_count), 128'(CD));
    tick();
    check("t6_err_wcmd_clears", 128'(err_wcmd_fifo), 128'd0);
    check("t6_err_wcmd_once", 128'(err_wcmd_cnt - e0), 128'd1);
    for (int i = 0; i < CD; i++) push_beat({32'h6000_0000 + 32'(i), $urandom}, 8'hAA, 1'b1, 1'b1);
    repeat (3) tick();
    check("t6_aw_hold_valid", 128'(axi_aw_valid), 128'd1);
    check("t6_aw_hold_addr_len", 128'({axi_aw_addr, axi_aw_len}), 128'({32'h6000, 8'd0}));
    axi_aw_ready = 1'b1;
    for (int i = 0; i < CD; i++) begin
      aw_tgt++;
      wait_aw(aw_tgt, "t6_drain_aw");
      w_tgt++;
      wait_w(w_tgt, "t6_drain_w");
      send_b(2'b00);
    end
    check("t6_outstanding_0", 128'(outstanding), 128'd0);

    // ---- reset mid-burst after beat 2 of 4 ----
    axi_w_ready = 1'b0;
    push_burst(32'h7000, 8'd3, 7);
    aw_tgt++;
    wait_aw(aw_tgt, "t7_aw");
    check("t7_w_valid_waiting", 128'(axi_w_valid), 128'd1);
    axi_w_ready = 1'b1;
    tick();
    tick();
    axi_w_ready = 1'b0;
    w_tgt += 2;
    check("t7_two_beats_sent", 128'(w_count), 128'(w_tgt));
    reset = 1'b1;
    tick();
    check("t7_rst_valids", 128'({axi_aw_valid, axi_w_valid, axi_w_last, axi_b_ready}), 128'd0);
    check("t7_rst_outstanding", 128'(outstanding), 128'd0);
    check("t7_rst_buses", 128'({axi_aw_addr, axi_aw_len, axi_w_data, axi_w_strb}), 128'd0);
    check("t7_rst_errs", 128'({err_wcmd_fifo, err_wdata_fifo, err_last, err_bresp}), 128'd0);
    reset = 1'b0;
    exp_aw.delete();
    exp_w.delete();
    axi_w_ready = 1'b1;
    axi_b_valid = 1'b1;
    axi_b_resp  = 2'b10;
    tick();
    axi_b_valid = 1'b0;
    axi_b_resp  = 2'b00;
    check("t7_stale_b_ignored", 128'(outstanding), 128'd0);
    check("t7_stale_b_no_err", 128'(err_bresp), 128'd0);
    check("t7_ready_after_rst", 128'({wr_cmd_ready, wr_data_ready}), 128'd3);
    repeat (4) tick();
    check("t7_no_more_w", 128'(w_count), 128'(w_tgt));
    check("t7_no_more_aw", 128'(aw_count), 128'(aw_tgt));
    push_burst(32'h8000, 8'd1, 8);
    aw_tgt++;
    wait_aw(aw_tgt, "t7_next_aw");
    w_tgt += 2;
    wait_w(w_tgt, "t7_next_w");
    send_b(2'b00);
    check("t7_outstanding_0", 128'(outstanding), 128'd0);
    check("end_queues_empty", 128'(exp_aw.size() + exp_w.size()), 128'd0);
    check("end_no_wdata_err", 128'(err_wdata_cnt), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_wr_buffer.md
AXI_WR_BUFFER -- requirements
Module: axi_wr_buffer

Interface
REQ-001 Parameter AXI_ADDR_WIDTH, default 32: write address width.
REQ-002 Parameter AXI_DATA_WIDTH, default 128: data width; SHALL be a multiple of 8, range 32..1024.
REQ-003 Parameter CMD_DEPTH, default 16: command FIFO depth; power of two, at least 2.
REQ-004 Parameter DATA_DEPTH, default 512: data FIFO depth in beats; power of two, at least 256.
REQ-005 Parameter MAX_OUTSTANDING, default 4: maximum AW-accepted bursts without a B response; range 1..15.
REQ-006 Port axi_clk, input, 1: single clock; one clock, all logic on its rising edge.
REQ-007 Port reset, input, 1: reset is synchronous and active-high.
REQ-008 Ports wr_req_en (in, 1), wr_addr_in (in, AXI_ADDR_WIDTH) and wr_burst_len (in, 8): command push; len is beats-1.
REQ-009 Port wr_cmd_ready, out, 1: low when the command FIFO is full.
REQ-010 Ports wr_data_valid (in, 1), wr_data_in (in, AXI_DATA_WIDTH), wr_data_strb (in, AXI_DATA_WIDTH/8) and wr_data_last (in, 1): data push.
REQ-011 Port wr_data_ready, out, 1: low when the data FIFO is full.
REQ-012 Ports axi_aw_valid (out, 1), axi_aw_ready (in, 1), axi_aw_addr (out, AXI_ADDR_WIDTH) and axi_aw_len (out, 8): AXI AW channel.
REQ-013 Ports axi_w_valid (out, 1), axi_w_ready (in, 1), axi_w_data (out, AXI_DATA_WIDTH), axi_w_strb (out, AXI_DATA_WIDTH/8) and axi_w_last (out, 1): AXI W channel.
REQ-014 Ports axi_b_valid (in, 1), axi_b_ready (out, 1) and axi_b_resp (in, 2): AXI B channel.
REQ-015 Port outstanding, out, 4: bursts in flight.
REQ-016 Ports err_wcmd_fifo, err_wdata_fifo, err_last and err_bresp, out, 1 each: one-cycle error pulses.

Function
REQ-017 Both FIFOs SHALL be synchronous first-word-fall-through; a push in cycle N SHALL be visible at the head in cycle N+1.
- Command FIFO push condition: wr_req_en && wr_cmd_ready.
- Data FIFO push condition: wr_data_valid && wr_data_ready.
REQ-018 The data FIFO entry SHALL hold {last, strb, data}; the FIFO SHALL keep an occupancy count of width log2(DATA_DEPTH)+1.
REQ-019 The FSM SHALL have states IDLE, AW and W.
REQ-020 IDLE->AW SHALL occur when all three hold: command FIFO non-empty, data count >= head len+1, and outstanding < MAX_OUTSTANDING.
REQ-021 axi_aw_valid SHALL be high exactly while in AW; axi_aw_addr and axi_aw_len SHALL be driven from the command head and stay stable until accepted.
REQ-022 AW->W SHALL occur on axi_aw_valid && axi_aw_ready; the command SHALL pop in the same cycle, and the beat counter SHALL load len.
REQ-023 In W, axi_w_valid SHALL be high, data and strb SHALL be driven from the data head, and axi_w_last SHALL equal (beat counter == 0).
- The counter SHALL be generated internally and SHALL NOT be taken from the stored last flag.
REQ-024 Each W handshake SHALL pop one data entry and decrement the counter.
- The handshake carrying axi_w_last SHALL return the FSM to IDLE.
- Earliest next AW SHALL be the cycle after return to IDLE.
REQ-025 If the stored last flag differs from the generated axi_w_last on any W handshake, err_last SHALL pulse; the burst SHALL still finish at the counted length.
REQ-026 axi_b_ready SHALL be high whenever outstanding > 0.
REQ-027 outstanding SHALL increment on an AW handshake and decrement on a B handshake; both in the same cycle SHALL leave it unchanged.
REQ-028 A B handshake with axi_b_resp != 2'b00 SHALL pulse err_bresp in the next cycle.
REQ-029 Overflow errors SHALL pulse in the next cycle; the offending entry SHALL be dropped and the FIFO SHALL be unchanged.
- err_wcmd_fifo: wr_req_en while the command FIFO is full.
- err_wdata_fifo: wr_data_valid while the data FIFO is full.
REQ-030 When outstanding == MAX_OUTSTANDING, the FSM SHALL stay in IDLE even with a complete burst buffered.
REQ-031 A simultaneous push and pop on a full FIFO SHALL be rejected as a push, because ready is low.
- A simultaneous push and pop on an empty FIFO SHALL not return the pushed entry in the same cycle.

Reset
REQ-032 While reset is high at a clock edge, the block SHALL enter IDLE and empty both FIFOs.
- outstanding, beat counter, axi_aw_valid, axi_w_valid, axi_w_last, axi_b_ready and all err_* SHALL be 0.
- axi_aw_addr, axi_aw_len, axi_w_data and axi_w_strb SHALL be 0.
- wr_cmd_ready and wr_data_ready SHALL be 1 in the cycle after reset deasserts.
REQ-033 Reset asserted mid-burst SHALL abort the burst with no further handshakes; in-flight B responses after reset SHALL be ignored.

Verification
REQ-034 Single burst: cmd addr 0x1000, len 3, then 4 beats with last on beat 4, and aw_ready/w_ready tied high.
- Required: one AW with addr 0x1000 and len 3.
- Required: 4 W beats in order, with w_last on beat 4 only.
- Required: outstanding goes 0->1, then ->0 after B OKAY.
REQ-035 Data gating: cmd len 7 with only 5 beats pushed -> axi_aw_valid SHALL stay 0; beats 6-8 pushed -> axi_aw_valid SHALL rise 2 cycles after beat 8.
REQ-036 Outstanding limit with MAX_OUTSTANDING=2: 3 complete bursts queued and no B -> exactly 2 AWs; the first B OKAY -> the third AW issues.
REQ-037 Backpressure: random w_ready at 50% -> data and strb SHALL match the push order bit-exactly, and w_valid SHALL never drop mid-burst.
REQ-038 Errors:
- Stored last on beat 2 of a len-3 burst -> err_last pulses once, and 4 beats are sent.
- B resp 2'b10 -> err_bresp pulses.
- Push into the full command FIFO -> err_wcmd_fifo pulses, and the FIFO count is unchanged.
REQ-039 Reset mid-burst after beat 2 of 4 -> all outputs return to reset values by the next cycle, and the next burst completes normally.
